sram_arbiter_2k16: RTL and testbench
====================================

// Module: sram_arbiter_2k16
// PURPOSE
//  Two-port round-robin arbiter/sequencer for the 2K x 16 word-addressable SRAM.
//  Accepts read/write requests from two masters (e.g. CPU, DMA) via req/ack handshake.
//  Generates the SRAM's low-true chip select, output enable and write enable strobes.
//  Drives the address bus and owns the bidirectional data bus, with turnaround between accesses.
// PARAMETERS
//  ADDR_W    11  SRAM word address width (2048 words)
//  DATA_W    16  SRAM data width
//  WAIT_CYC  1   cycles spent in ACCESS per transfer; legal range >= 1
// PORTS
//  clk             in     1       system clock, all logic on rising edge
//  reset           in     1       synchronous, active-high reset
//  rq0_req         in     1       requester 0 request; held high until rq0_ack
//  rq0_we          in     1       1 = write, 0 = read; stable while rq0_req high
//  rq0_addr        in     ADDR_W  word address; stable while rq0_req high
//  rq0_wdata       in     DATA_W  write data; stable while rq0_req high
//  rq0_ack         out    1       one-cycle completion pulse
//  rq0_rdata       out    DATA_W  read data; valid with rq0_ack, held until next rq0 read
//  rq1_*           ...    ...     identical set for requester 1
//  sram_adx        out    ADDR_W  SRAM address
//  sram_cs_n       out    1       chip select, low true
//  sram_oe_n       out    1       output enable, low true
//  sram_we_n       out    1       write enable, low true
//  sram_data       inout  DATA_W  SRAM data bus; Z unless writing
//  busy            out    1       high in every state except IDLE
// BEHAVIOUR
//  Reset: state IDLE; cs_n/oe_n/we_n = 1; sram_data = Z; sram_adx = 0; acks = 0;
//   rdata = 0; busy = 0; round-robin pointer favours rq0.
//  FSM: IDLE -> SETUP -> ACCESS (WAIT_CYC cycles) -> DONE -> IDLE.
//   IDLE:   on any req, grant winner; latch its we/addr/wdata into internal regs.
//   SETUP:  sram_adx = latched addr; cs_n = 0; oe_n = we_n = 1; bus Z.
//   ACCESS: read: oe_n = 0, bus Z. Write: we_n = 0, bus driven with latched wdata.
//           A down-counter loaded with WAIT_CYC-1 in SETUP; leave when it reaches 0.
//           Read data is sampled into the winner's rdata on the last ACCESS edge.
//   DONE:   cs_n/oe_n/we_n = 1; write data still driven (hold); winner's ack = 1.
//           Next edge: bus Z, back to IDLE (IDLE acts as bus turnaround).
//  Latency: req high at edge N in IDLE -> ack high in cycle N+2+WAIT_CYC.
//   Throughput: one access per 3+WAIT_CYC cycles.
//  Arbitration: lone requester always wins. Both requesting: the one not served last wins.
//   Pointer updates only on grant.
//  Handshake: requester drops req the cycle after ack. A req still high in IDLE after ack
//   is a new request.
//  Safety: oe_n and we_n are never both 0. sram_data is driven only while state is ACCESS-write
//   or DONE-write. oe_n = 0 never coincides with bus drive.
//  Address: full ADDR_W used; 0 and 2^ADDR_W-1 valid; no wrap logic needed.
//  Reset mid-operation: the next edge forces IDLE with strobes high and bus Z; no ack is issued.
//   A write interrupted in ACCESS leaves the target word undefined. Pointer returns to rq0.
//  Request input changes while not granted are ignored until IDLE sampling.
// STRUCTURE
//  Package sram_ctrl_pkg:
//   - typedef enum {S_IDLE, S_SETUP, S_ACCESS, S_DONE} sram_state_t
//   - SRAM_WORDS = 2048, SRAM_AW = 11, SRAM_DW = 16
//  Sub-module rr_arbiter2: 2-way round-robin; inputs req[1:0], grant_en;
//   output one-hot gnt[1:0]; holds the last-served pointer.
//  Top: FSM, wait counter, latched request regs, tri-state driver, rdata regs.
// TESTING (bench uses a behavioural 2K x 16 SRAM model on the bus)
//  1. rq0 write 0x005 = 0xBEEF: ack in cycle 3; we_n low exactly 1 cycle; then rq0 read 0x005
//     -> rq0_rdata = 0xBEEF with ack.
//  2. Both reqs rise together after reset -> rq0 acked first, rq1 acked 4 cycles later.
//  3. Both reqs held continuously for 8 accesses -> acks strictly alternate rq0, rq1, ...
//  4. Write 0x000 = 0x1234 and 0x7FF = 0xABCD -> read back each; no aliasing.
//  5. reset pulsed during ACCESS of an rq1 write -> next cycle all strobes 1, bus Z, no rq1_ack;
//     simultaneous reqs after reset grant rq0.
//  6. WAIT_CYC = 3 read -> oe_n low 3 cycles, ack in cycle 5. Assertion throughout:
//     never (oe_n == 0 && we_n == 0); never bus driven while oe_n == 0.

Source files
------------

// File: rtl/sram_arbiter_2k16_pkg.sv
// Shared types and sizes for the 2K x 16 SRAM arbiter.
// Imported by the interface, arbiter and top.
package sram_ctrl_pkg;

  localparam int SRAM_WORDS = 2048;
  localparam int SRAM_AW    = 11;
  localparam int SRAM_DW    = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_DONE
  } sram_state_t;

endpackage

// File: rtl/sram_arbiter_2k16_if.sv
// Requester-side req/ack bundle.
// A requester uses master; the arbiter uses slave.
interface sram_arbiter_2k16_if #(
  parameter int AW = sram_ctrl_pkg::SRAM_AW,
  parameter int DW = sram_ctrl_pkg::SRAM_DW
);
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/sram_arbiter_2k16_rr_arbiter2.sv
// Two-way round-robin grant logic.
// The last-served pointer moves only on a grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic [1:0] gnt_o
);

  logic last_q;

  // Lone requester wins; on a tie the one not served last wins
  always_comb begin
    gnt_o = '0;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = '0;
    endcase
  end

  // Remember who was served; reset value makes rq0 favoured
  always_ff @(posedge clk) begin
    if (reset)
      last_q <= 1'b1;
    else if (grant_en_i && |req_i)
      last_q <= gnt_o[1];
  end

endmodule

// File: rtl/sram_arbiter_2k16.sv
// Round-robin sequencer for two masters sharing a 2K x 16 SRAM.
// IDLE -> SETUP -> ACCESS x WAIT_CYC -> DONE, IDLE doubles as turnaround.
module sram_arbiter_2k16
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W   = SRAM_AW,
  parameter int DATA_W   = SRAM_DW,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              reset,
  sram_arbiter_2k16_if.slave rq0,
  sram_arbiter_2k16_if.slave rq1,
  output logic [ADDR_W-1:0] sram_adx_o,
  output logic              sram_cs_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  inout  wire  [DATA_W-1:0] sram_data_io,
  output logic              busy_o
);

  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

  sram_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q;
  logic              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              grant_en;
  logic              in_acc;
  logic              last_acc;
  logic              drive;

  assign req = {rq1.req, rq0.req};

  rr_arbiter2 u_arb (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req),
    .grant_en_i (grant_en),
    .gnt_o      (gnt)
  );

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, grant strobe and wait-counter load/decrement
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          grant_en = 1'b1;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = CW'(WAIT_CYC - 1);
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (cnt_q == '0)
          state_d = S_DONE;
        else
          cnt_d = cnt_q - 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the winner's request so masters may change inputs afterwards
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant_en) begin
      sel_q   <= gnt[1];
      we_q    <= gnt[1] ? rq1.we    : rq0.we;
      addr_q  <= gnt[1] ? rq1.addr  : rq0.addr;
      wdata_q <= gnt[1] ? rq1.wdata : rq0.wdata;
    end
  end

  assign in_acc   = (state_q == S_ACCESS);
  assign last_acc = in_acc && (cnt_q == '0);

  // Sample read data on the final ACCESS edge into the winner's register
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (last_acc && !we_q) begin
      if (sel_q)
        rdata1_q <= sram_data_io;
      else
        rdata0_q <= sram_data_io;
    end
  end

  // Bus is driven only for a write, through ACCESS and the DONE hold cycle
  assign drive        = we_q && (in_acc || state_q == S_DONE);
  assign sram_data_io = drive ? wdata_q : {DATA_W{1'bz}};

  assign sram_adx_o  = addr_q;
  assign sram_cs_n_o = !((state_q == S_SETUP) || in_acc);
  assign sram_oe_n_o = !(in_acc && !we_q);
  assign sram_we_n_o = !(in_acc && we_q);
  assign busy_o      = (state_q != S_IDLE);

  assign rq0.ack   = (state_q == S_DONE) && !sel_q;
  assign rq1.ack   = (state_q == S_DONE) && sel_q;
  assign rq0.rdata = rdata0_q;
  assign rq1.rdata = rdata1_q;

endmodule

// File: tb/tb_sram_arbiter_2k16.sv
// Directed bench for sram_arbiter_2k16 with a behavioural 2K x 16 SRAM.
// A second instance runs with WAIT_CYC = 3.
module tb_sram_arbiter_2k16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sram_arbiter_2k16_if rq0 ();
  sram_arbiter_2k16_if rq1 ();
  sram_arbiter_2k16_if rq0b ();
  sram_arbiter_2k16_if rq1b ();

  wire  [15:0] sdata;
  logic [10:0] adx;
  logic        cs_n, oe_n, we_n, busy;
  wire  [15:0] sdata3;
  logic [10:0] adx3;
  logic        cs_n3, oe_n3, we_n3, busy3;

  sram_arbiter_2k16 dut (
    .clk          (clk),
    .reset        (reset),
    .rq0          (rq0.slave),
    .rq1          (rq1.slave),
    .sram_adx_o   (adx),
    .sram_cs_n_o  (cs_n),
    .sram_oe_n_o  (oe_n),
    .sram_we_n_o  (we_n),
    .sram_data_io (sdata),
    .busy_o       (busy)
  );

  sram_arbiter_2k16 #(.WAIT_CYC(3)) dut3 (
    .clk          (clk),
    .reset        (reset),
    .rq0          (rq0b.slave),
    .rq1          (rq1b.slave),
    .sram_adx_o   (adx3),
    .sram_cs_n_o  (cs_n3),
    .sram_oe_n_o  (oe_n3),
    .sram_we_n_o  (we_n3),
    .sram_data_io (sdata3),
    .busy_o       (busy3)
  );

  logic [15:0] mem [0:2047];
  assign sdata  = (!cs_n && !oe_n) ? mem[adx] : 16'hzzzz;
  assign sdata3 = (!cs_n3 && !oe_n3) ? ({5'd0, adx3} ^ 16'h5A5A) : 16'hzzzz;

  always @(posedge clk)
    if (!cs_n && !we_n) mem[adx] <= sdata;

  int checks = 0;
  int errors = 0;
  int we_low = 0;
  int oe_low3 = 0;

  always @(posedge clk) begin
    if (!we_n) we_low++;
    if (!oe_n3) oe_low3++;
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (!oe_n && !we_n) begin
        errors++;
        $display("FAIL strobe_excl: oe_n=%b we_n=%b both low", oe_n, we_n);
      end
      if (!oe_n3 && !we_n3) begin
        errors++;
        $display("FAIL strobe_excl3: oe_n=%b we_n=%b both low", oe_n3, we_n3);
      end
      if ((!oe_n || !we_n) && cs_n) begin
        errors++;
        $display("FAIL cs_cover: cs_n=%b while oe_n=%b we_n=%b", cs_n, oe_n, we_n);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic access(input bit p, input logic we, input logic [10:0] a,
                        input logic [15:0] wd, output logic [15:0] rd,
                        output int lat);
    if (!p) begin
      rq0.we = we; rq0.addr = a; rq0.wdata = wd; rq0.req = 1'b1;
    end else begin
      rq1.we = we; rq1.addr = a; rq1.wdata = wd; rq1.req = 1'b1;
    end
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!(p ? rq1.ack : rq0.ack) && lat < 20);
    rd = p ? rq1.rdata : rq0.rdata;
    rq0.req = 1'b0;
    rq1.req = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          p;
    logic        we;
    logic [10:0] a;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t v [8];

  initial begin : main
    logic [15:0] rd;
    int lat, t0, t1, n;
    int ord [8];

    rq0.req = 0; rq0.we = 0; rq0.addr = '0; rq0.wdata = '0;
    rq1.req = 0; rq1.we = 0; rq1.addr = '0; rq1.wdata = '0;
    rq0b.req = 0; rq0b.we = 0; rq0b.addr = '0; rq0b.wdata = '0;
    rq1b.req = 0; rq1b.we = 0; rq1b.addr = '0; rq1b.wdata = '0;

    v[0] = '{0, 1, 11'h005, 16'hBEEF, 16'h0000};
    v[1] = '{0, 0, 11'h005, 16'h0000, 16'hBEEF};
    v[2] = '{0, 1, 11'h000, 16'h1234, 16'h0000};
    v[3] = '{1, 1, 11'h7FF, 16'hABCD, 16'h0000};
    v[4] = '{1, 0, 11'h000, 16'h0000, 16'h1234};
    v[5] = '{0, 0, 11'h7FF, 16'h0000, 16'hABCD};
    v[6] = '{1, 1, 11'h400, 16'h0F0F, 16'h0000};
    v[7] = '{1, 0, 11'h400, 16'h0000, 16'h0F0F};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_strobes", {29'd0, cs_n, oe_n, we_n}, 32'h7);
    chk("rst_adx", {21'd0, adx}, 32'h0);
    chk("rst_busy_ack", {29'd0, busy, rq0.ack, rq1.ack}, 32'h0);
    chk("rst_rdata", {rq0.rdata, rq1.rdata}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      we_low = 0;
      access(v[i].p, v[i].we, v[i].a, v[i].wd, rd, lat);
      chk($sformatf("lat_v%0d", i), lat, 3);
      chk($sformatf("we_cyc_v%0d", i), we_low, v[i].we ? 1 : 0);
      if (!v[i].we)
        chk($sformatf("rdata_v%0d", i), {16'd0, rd}, {16'd0, v[i].exp});
    end
    chk("rdata_hold0", {16'd0, rq0.rdata}, 32'hABCD);
    chk("rdata_hold1", {16'd0, rq1.rdata}, 32'h0F0F);

    rq0.we = 1; rq0.addr = 11'h010; rq0.wdata = 16'h1111;
    rq1.we = 1; rq1.addr = 11'h011; rq1.wdata = 16'h2222;
    rq0.req = 1; rq1.req = 1;
    t0 = 0; t1 = 0;
    for (int c = 1; c <= 30 && !(t0 > 0 && t1 > 0); c++) begin
      @(posedge clk); #1;
      if (rq0.ack && rq0.req) begin t0 = c; rq0.req = 0; end
      if (rq1.ack && rq1.req) begin t1 = c; rq1.req = 0; end
    end
    chk("tie_ack0", t0, 3);
    chk("tie_ack1", t1, 7);
    @(posedge clk); #1;

    rq0.we = 0; rq0.addr = 11'h010;
    rq1.we = 0; rq1.addr = 11'h011;
    rq0.req = 1; rq1.req = 1;
    n = 0;
    for (int c = 0; c < 60 && n < 8; c++) begin
      @(posedge clk); #1;
      if (rq0.ack && n < 8) begin ord[n] = 0; n++; end
      if (rq1.ack && n < 8) begin ord[n] = 1; n++; end
      if (n == 8) begin rq0.req = 0; rq1.req = 0; end
    end
    rq0.req = 0; rq1.req = 0;
    chk("alt_count", n, 8);
    for (int i = 0; i < 8; i++)
      if (i < n) chk($sformatf("alt_ord%0d", i), ord[i], i % 2);
    chk("alt_rd0", {16'd0, rq0.rdata}, 32'h1111);
    chk("alt_rd1", {16'd0, rq1.rdata}, 32'h2222);
    @(posedge clk); #1;

    rq1.we = 1; rq1.addr = 11'h100; rq1.wdata = 16'h5555; rq1.req = 1;
    for (int c = 0; c < 10 && we_n; c++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_in_write", {31'd0, we_n}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_strobes", {29'd0, cs_n, oe_n, we_n}, 32'h7);
    chk("rst_mid_busy_ack", {30'd0, busy, rq1.ack}, 32'h0);
    chk("rst_mid_rdata", {rq0.rdata, rq1.rdata}, 32'h0);
    rq1.req = 0;
    reset = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (rq1.ack || rq0.ack) n++;
    end
    chk("rst_mid_no_ack", n, 0);

    rq0.we = 0; rq0.addr = 11'h005;
    rq1.we = 0; rq1.addr = 11'h000;
    rq0.req = 1; rq1.req = 1;
    t0 = 0; t1 = 0;
    for (int c = 1; c <= 30 && !(t0 > 0 && t1 > 0); c++) begin
      @(posedge clk); #1;
      if (rq0.ack && rq0.req) begin t0 = c; rq0.req = 0; end
      if (rq1.ack && rq1.req) begin t1 = c; rq1.req = 0; end
    end
    chk("post_rst_ack0", t0, 3);
    chk("post_rst_ack1", t1, 7);
    chk("post_rst_rd0", {16'd0, rq0.rdata}, 32'hBEEF);
    chk("post_rst_rd1", {16'd0, rq1.rdata}, 32'h1234);
    @(posedge clk); #1;

    oe_low3 = 0;
    rq0b.we = 0; rq0b.addr = 11'h0AA; rq0b.req = 1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rq0b.ack && lat < 20);
    rq0b.req = 0;
    chk("w3_lat", lat, 5);
    chk("w3_oe_cycles", oe_low3, 3);
    chk("w3_rdata", {16'd0, rq0b.rdata}, 32'h5AF0);
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
